bin_window_gen: RTL and testbench

Streaming window generator directly upstream of the per-pixel binary conv+pool channel array. It accepts a raster-order stream of 1-bit activations for one feature-map plane, buffers the most recent six rows, and emits each 6×6 window at stride 2 in both directions. Each emitted window is exactly the input one conv-5×5 + max-pool-2×2 output pixel needs, driven on all output channels in parallel.

---
 rtl/bin_window_gen.sv | 110 +++++++++++
 tb/tb_bin_window_gen.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_window_gen.sv
// Streaming 6x6 / stride-2 window generator for a 1-bit raster plane.
// Keeps the last six rows in a circular row store and emits one window per conv+pool output pixel.
module bin_window_gen #(
    parameter int IMG_W = 12,
    parameter int IMG_H = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic                         pix_in,
    input  logic                         pix_sof,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic                         window [0:35],
    output logic [$clog2(IMG_H/2)-1:0]   win_row,
    output logic [$clog2(IMG_W/2)-1:0]   win_col,
    output logic                         frame_done
);
    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int WRW = $clog2(IMG_H/2);
    localparam int WCW = $clog2(IMG_W/2);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic [CW-1:0]    col, curCol;
    logic [RW-1:0]    row, curRow;
    logic [2:0]       slot, curSlot;
    logic [IMG_W-1:0] rowBuf [0:5];
    logic             accept;
    logic             trigger;
    logic             nextWin [0:35];

    // Slot holding the row that is 'offs' rows after the slot 'base' (mod 6).
    function automatic logic [2:0] slotOf(input logic [2:0] base, input int offs);
        int t;
        t = int'(base) + offs;
        if (t >= 6) t = t - 6;
        return 3'(t);
    endfunction

    assign pix_ready = !(win_valid && !win_ready);
    assign accept    = pix_valid && pix_ready;

    // A start-of-frame pixel is forced to (0,0) whatever the counters say.
    assign curCol  = pix_sof ? '0   : col;
    assign curRow  = pix_sof ? '0   : row;
    assign curSlot = pix_sof ? 3'd0 : slot;

    // row >= 5 with (row-5) even is the same as row >= 5 and row odd.
    assign trigger = accept && (curRow >= RW'(5)) && curRow[0]
                            && (curCol >= CW'(5)) && curCol[0];

    always_comb begin
        nextWin = '{default: 1'b0};
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                nextWin[i*6+j] = rowBuf[slotOf(curSlot, i + 1)][curCol - CW'(5) + CW'(j)];
            end
        end
        nextWin[35] = pix_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            slot <= '0;
            for (int i = 0; i < 6; i++) rowBuf[i] <= '0;
        end else if (accept) begin
            rowBuf[curSlot][curCol] <= pix_in;
            if (curCol == LAST_COL) begin
                col <= '0;
                if (curRow == LAST_ROW) begin
                    row  <= '0;
                    slot <= '0;
                end else begin
                    row  <= curRow + RW'(1);
                    slot <= (curSlot == 3'd5) ? 3'd0 : curSlot + 3'd1;
                end
            end else begin
                col  <= curCol + CW'(1);
                row  <= curRow;
                slot <= curSlot;
            end
        end
    end

    // Stride-2 spacing guarantees a trigger never lands on a still-pending window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            window     <= '{default: 1'b0};
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= accept && (curRow == LAST_ROW) && (curCol == LAST_COL);
            if (trigger) begin
                win_valid <= 1'b1;
                window    <= nextWin;
                win_row   <= WRW'((curRow - RW'(5)) >> 1);
                win_col   <= WCW'((curCol - CW'(5)) >> 1);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bin_window_gen.sv
// Bench for bin_window_gen: directed and random frames checked every cycle
// against a whole-frame array model of the stride-2 6x6 windowing.
module tb_bin_window_gen;
    localparam int W = 12;
    localparam int H = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_valid = 1'b0;
    logic pix_in = 1'b0;
    logic pix_sof = 1'b0;
    logic win_ready = 1'b1;
    logic pix_ready, win_valid, frame_done;
    logic window [0:35];
    logic [2:0] win_row, win_col;
    logic [35:0] dutWin;

    typedef struct {
        logic [35:0] bits;
        int          r;
        int          c;
    } win_t;

    int checks = 0;
    int failures = 0;
    win_t expQ[$];
    logic [35:0] logWin[$];
    int logPos[$];
    logic img [0:H-1][0:W-1];
    int mRow = 0;
    int mCol = 0;
    logic expFd = 1'b0;
    int dutFdCount = 0;
    int stallCycles = 0;
    int readyMode = 0;
    int stallLeft = 0;

    bin_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_in(pix_in),
        .pix_sof(pix_sof),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .window(window),
        .win_row(win_row),
        .win_col(win_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        dutWin = '0;
        for (int k = 0; k < 36; k++) dutWin[k] = window[k];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the frame is kept as a plain 2-D array indexed by raster
    // position; a window is cut straight out of it whenever a trigger position is accepted.
    always @(posedge clk or negedge rst_n) begin
        int r, c;
        bit acc;
        win_t w;
        if (!rst_n) begin
            expQ.delete();
            mRow = 0;
            mCol = 0;
            expFd = 1'b0;
        end else begin
            expFd = 1'b0;
            acc = pix_valid && !(expQ.size() > 0 && !win_ready);
            if (expQ.size() > 0 && win_ready) w = expQ.pop_front();
            if (acc) begin
                r = pix_sof ? 0 : mRow;
                c = pix_sof ? 0 : mCol;
                img[r][c] = pix_in;
                if (r >= 5 && (r - 5) % 2 == 0 && c >= 5 && (c - 5) % 2 == 0) begin
                    for (int i = 0; i < 6; i++)
                        for (int j = 0; j < 6; j++)
                            w.bits[i*6+j] = img[r-5+i][c-5+j];
                    w.r = (r - 5) / 2;
                    w.c = (c - 5) / 2;
                    expQ.push_back(w);
                end
                if (r == H - 1 && c == W - 1) expFd = 1'b1;
                c++;
                if (c == W) begin
                    c = 0;
                    r++;
                    if (r == H) r = 0;
                end
                mRow = r;
                mCol = c;
            end
        end
    end

    // Per-cycle compare on the falling edge, plus a log of what the DUT handed downstream.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("pix_ready", 64'(pix_ready), 64'(!(expQ.size() > 0 && !win_ready)));
            checkOutput("win_valid", 64'(win_valid), 64'(expQ.size() > 0));
            checkOutput("frame_done", 64'(frame_done), 64'(expFd));
            if (expQ.size() > 0) begin
                checkOutput("window", 64'(dutWin), 64'(expQ[0].bits));
                checkOutput("win_row", 64'(win_row), 64'(expQ[0].r));
                checkOutput("win_col", 64'(win_col), 64'(expQ[0].c));
            end
            if (!pix_ready) stallCycles++;
            if (frame_done) dutFdCount++;
            if (win_valid && win_ready) begin
                logWin.push_back(dutWin);
                logPos.push_back(int'(win_row) * 4 + int'(win_col));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (readyMode == 1) begin
                win_ready = ($urandom_range(0, 2) != 0);
            end else if (readyMode == 2 && stallLeft > 0 && win_valid) begin
                win_ready = 1'b0;
                stallLeft--;
            end else begin
                win_ready = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sendPixel(input logic v, input logic s);
        bit got;
        got = 1'b0;
        pix_valid = 1'b1;
        pix_in = v;
        pix_sof = s;
        for (int g = 0; g < 200 && !got; g++) begin
            @(negedge clk);
            got = pix_ready;
            tick();
        end
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic patPix(input int pat, input int r, input int c);
        case (pat)
            0:       return 1'b1;
            1:       return 1'((r * W + c) % 2);
            2:       return 1'(r == 5 && c == 5);
            3:       return 1'(((r * W + c) % 2) == 0);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic applyStimulus(input int pat, input int firstIdx, input int lastIdx,
                                 input bit sof, input bit gaps);
        for (int k = firstIdx; k <= lastIdx; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) tick();
            sendPixel(patPix(pat, k / W, k % W), sof && (k == firstIdx));
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (expQ.size() > 0 && g < 200) begin
            tick();
            g++;
        end
        if (expQ.size() > 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic clearLog();
        logWin.delete();
        logPos.delete();
        dutFdCount = 0;
        stallCycles = 0;
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_pix_ready"}, 64'(pix_ready), 64'd1);
        checkOutput({name, "_win_valid"}, 64'(win_valid), 64'd0);
        checkOutput({name, "_frame_done"}, 64'(frame_done), 64'd0);
        checkOutput({name, "_window"}, 64'(dutWin), 64'd0);
        checkOutput({name, "_win_row"}, 64'(win_row), 64'd0);
        checkOutput({name, "_win_col"}, 64'(win_col), 64'd0);
    endtask

    task automatic checkFrameLog(input string name, input int first, input logic [35:0] bits, input bit checkBits);
        for (int k = first; k < logWin.size() && k < first + 16; k++) begin
            if (checkBits) checkOutput({name, "_bits"}, 64'(logWin[k]), 64'(bits));
            checkOutput({name, "_raster"}, 64'(logPos[k]), 64'(k - first));
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) tick();
        checkReset("reset");
        rst_n = 1'b1;
        tick();

        $display("[TB] all-ones frame");
        readyMode = 0;
        clearLog();
        applyStimulus(0, 0, W*H-1, 1'b1, 1'b0);
        drain();
        checkOutput("ones_count", 64'(logWin.size()), 64'd16);
        checkOutput("ones_frame_done", 64'(dutFdCount), 64'd1);
        checkFrameLog("ones", 0, 36'hFFFFFFFFF, 1'b1);

        $display("[TB] checkerboard then single pixel at (5,5)");
        clearLog();
        applyStimulus(1, 0, W*H-1, 1'b1, 1'b0);
        applyStimulus(2, 0, W*H-1, 1'b1, 1'b0);
        drain();
        checkOutput("chk_count", 64'(logWin.size()), 64'd32);
        checkFrameLog("chk", 0, 36'hAAAAAAAAA, 1'b1);
        if (logWin.size() >= 21) begin
            checkOutput("dot_w00", 64'(logWin[16]), 64'h800000000);
            checkOutput("dot_w01", 64'(logWin[17]), 64'h200000000);
            checkOutput("dot_w02", 64'(logWin[18]), 64'h080000000);
            checkOutput("dot_w03", 64'(logWin[19]), 64'h000000000);
            checkOutput("dot_w10", 64'(logWin[20]), 64'h000800000);
        end

        $display("[TB] consumer stall after first window");
        readyMode = 2;
        stallLeft = 10;
        clearLog();
        applyStimulus(1, 0, W*H-1, 1'b1, 1'b0);
        drain();
        checkOutput("stall_cycles", 64'(stallCycles), 64'd10);
        checkOutput("stall_count", 64'(logWin.size()), 64'd16);
        checkFrameLog("stall", 0, 36'hAAAAAAAAA, 1'b1);
        readyMode = 0;

        $display("[TB] back-to-back frames, second inverted");
        clearLog();
        applyStimulus(1, 0, W*H-1, 1'b1, 1'b0);
        applyStimulus(3, 0, W*H-1, 1'b1, 1'b0);
        drain();
        checkOutput("b2b_count", 64'(logWin.size()), 64'd32);
        checkOutput("b2b_frame_done", 64'(dutFdCount), 64'd2);
        checkFrameLog("b2b_a", 0, 36'hAAAAAAAAA, 1'b1);
        checkFrameLog("b2b_b", 16, 36'h555555555, 1'b1);

        $display("[TB] sof abort at pixel 70");
        clearLog();
        applyStimulus(4, 0, 69, 1'b1, 1'b0);
        applyStimulus(4, 0, W*H-1, 1'b1, 1'b0);
        drain();
        checkOutput("abort_count", 64'(logWin.size()), 64'd19);
        checkOutput("abort_frame_done", 64'(dutFdCount), 64'd1);
        checkFrameLog("abort", 3, 36'h0, 1'b0);

        $display("[TB] reset pulse mid row 7");
        readyMode = 1;
        applyStimulus(4, 0, 7*W+3, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        tick();
        rst_n = 1'b1;
        clearLog();
        applyStimulus(4, 0, W*H-1, 1'b0, 1'b1);
        drain();
        checkOutput("rst_count", 64'(logWin.size()), 64'd16);
        checkOutput("rst_frame_done", 64'(dutFdCount), 64'd1);
        checkFrameLog("rst", 0, 36'h0, 1'b0);

        $display("[TB] random frames with gaps and random consumer");
        clearLog();
        for (int f = 0; f < 3; f++) applyStimulus(4, 0, W*H-1, 1'b1, 1'b1);
        drain();
        checkOutput("rand_count", 64'(logWin.size()), 64'd48);
        checkOutput("rand_frame_done", 64'(dutFdCount), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
